// File: rtl/leb128_imm_decoder_pkg.sv
// Shared constants, state encoding and helpers for the LEB128 immediate decoder.
package leb128_imm_decoder_pkg;

  localparam int unsigned LEB_MAX_BYTES_32 = 5;
  localparam int unsigned LEB_MAX_BYTES_64 = 10;
  localparam int unsigned LEB_W32          = 32;
  localparam int unsigned LEB_W64          = 64;
  localparam int unsigned ACC_W            = 64;
  localparam int unsigned LEN_W            = 4;
  localparam int unsigned BYTE_W           = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_DONE   = 2'd2
  } leb_state_t;

  // Maximum encoded length for the selected target width.
  function automatic logic [LEN_W-1:0] max_bytes(input logic is64);
    return is64 ? LEN_W'(LEB_MAX_BYTES_64) : LEN_W'(LEB_MAX_BYTES_32);
  endfunction

endpackage

// File: rtl/leb128_imm_decoder_if.sv
// Command / byte-stream / result handshake bundle of the LEB128 decoder.
interface leb128_imm_decoder_if;

  logic                                          cmd_valid;
  logic                                          cmd_ready;
  logic                                          cmd_signed;
  logic                                          cmd_is64;
  logic                                          in_valid;
  logic                                          in_ready;
  logic [leb128_imm_decoder_pkg::BYTE_W-1:0]     in_byte;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [leb128_imm_decoder_pkg::ACC_W-1:0]      out_value;
  logic [leb128_imm_decoder_pkg::LEN_W-1:0]      out_len;
  logic                                          out_error;

  modport master (
    output cmd_valid, cmd_signed, cmd_is64, in_valid, in_byte, out_ready,
    input  cmd_ready, in_ready, out_valid, out_value, out_len, out_error
  );

  modport slave (
    input  cmd_valid, cmd_signed, cmd_is64, in_valid, in_byte, out_ready,
    output cmd_ready, in_ready, out_valid, out_value, out_len, out_error
  );

endinterface

// File: rtl/leb128_final_check.sv
// Final-byte analysis: sign-extension mask and (optional) surplus-bit check.
// Build option: define LEB128_STRICT_EN to reject final bytes carrying bits
// beyond the target width at maximum length.
module leb128_final_check
  import leb128_imm_decoder_pkg::*;
(
  input  logic [6:0]       fin_bits,
  input  logic [LEN_W-1:0] len,
  input  logic             sgn,
  input  logic             is64,
  output logic             strict_err_c,
  output logic [ACC_W-1:0] sext_mask_c
);

  logic [6:0] nbits;
  logic [6:0] width;

  // Fill bits [width-1:7*len] when the final payload's sign bit is set.
  always_comb begin
    nbits       = 7'(len) * 7'd7;
    width       = is64 ? 7'(LEB_W64) : 7'(LEB_W32);
    sext_mask_c = '0;
    if (sgn && fin_bits[6] && (nbits < width)) begin
      sext_mask_c = ~((64'd1 << nbits) - 64'd1) &
                    (is64 ? {ACC_W{1'b1}} : 64'h0000_0000_FFFF_FFFF);
    end
  end

`ifdef LEB128_STRICT_EN
  // At maximum length, bits past the target width must be zero or sign copies.
  always_comb begin
    strict_err_c = 1'b0;
    if (len == max_bytes(is64)) begin
      case ({is64, sgn})
        2'b00:   strict_err_c = |fin_bits[6:4];
        2'b01:   strict_err_c = !((fin_bits[6:3] == 4'h0) || (fin_bits[6:3] == 4'hF));
        2'b10:   strict_err_c = |fin_bits[6:1];
        default: strict_err_c = !((fin_bits == 7'h00) || (fin_bits == 7'h7F));
      endcase
    end
  end
`else
  // Surplus bits are silently dropped in the permissive build.
  logic unused_fin_bits;
  assign unused_fin_bits = ^fin_bits[5:0];
  assign strict_err_c    = 1'b0;
`endif

endmodule

// File: rtl/leb128_imm_decoder.sv
// LEB128 (wasm varuint/varint) immediate decoder, one code byte per cycle.
// Build option: LEB128_STRICT_EN enables strict final-byte width checking.
module leb128_imm_decoder
  import leb128_imm_decoder_pkg::*;
#(
  parameter bit USE_64B = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  leb128_imm_decoder_if.slave bus
);

  leb_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic             sgn_q, is64_q;
  logic             cmd_ready_q, in_ready_q, out_valid_q, out_error_q;
  logic [ACC_W-1:0] out_value_q;
  logic [LEN_W-1:0] out_len_q;

  logic             cmd_fire, in_fire, out_fire, done_fire;
  logic [LEN_W-1:0] cnt_inc;
  logic [5:0]       shamt;
  logic             is_last, overlong, dec_err, strict_err;
  logic [ACC_W-1:0] acc_new, sext_mask, val64, val;

  // Handshakes and the per-byte accumulate / finalise datapath.
  always_comb begin
    cmd_fire  = bus.cmd_valid & cmd_ready_q & ~flush;
    in_fire   = bus.in_valid & in_ready_q & ~flush;
    out_fire  = out_valid_q & bus.out_ready & ~flush;
    cnt_inc   = cnt_q + 4'd1;
    shamt     = 6'({2'b00, cnt_q} * 6'd7);
    acc_new   = acc_q | (ACC_W'(bus.in_byte[6:0]) << shamt);
    is_last   = ~bus.in_byte[7];
    overlong  = bus.in_byte[7] & (cnt_inc == max_bytes(is64_q));
    done_fire = in_fire & (is_last | overlong);
    dec_err   = overlong | (is_last & strict_err);
    val64     = acc_new | sext_mask;
    val       = is64_q ? val64 : {32'h0, val64[31:0]};
  end

  leb128_final_check u_final_check (
    .fin_bits     (bus.in_byte[6:0]),
    .len          (cnt_inc),
    .sgn          (sgn_q),
    .is64         (is64_q),
    .strict_err_c (strict_err),
    .sext_mask_c  (sext_mask)
  );

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (cmd_fire)  state_d = S_DECODE;
        S_DECODE: if (done_fire) state_d = S_DONE;
        S_DONE:   if (out_fire)  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State register and registered handshake readies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == S_IDLE);
      in_ready_q  <= (state_d == S_DECODE);
    end
  end

  // Mode, accumulator and byte count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      sgn_q  <= 1'b0;
      is64_q <= 1'b0;
    end else if (cmd_fire) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      sgn_q  <= bus.cmd_signed;
      is64_q <= bus.cmd_is64 & USE_64B;
    end else if (in_fire) begin
      acc_q  <= acc_new;
      cnt_q  <= cnt_inc;
    end
  end

  // Result registers, held until the consumer accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_len_q   <= '0;
      out_error_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (done_fire) begin
      out_valid_q <= 1'b1;
      out_value_q <= dec_err ? '0 : val;
      out_len_q   <= cnt_inc;
      out_error_q <= dec_err;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  // in_ready drops in the flush cycle so the presented byte is not taken.
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q & ~flush;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_error = out_error_q;

endmodule

// File: tb/tb_leb128_imm_decoder.sv
// Scoreboard bench for leb128_imm_decoder with directed LEB128 vectors.
module tb_leb128_imm_decoder;

  typedef struct {
    logic [63:0] value;
    logic [3:0]  len;
    logic        err;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  bq[$];
  int          n_chk    = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          cmd_cyc  = 0;
  int          rise_cyc = 0;
  logic        prev_ov  = 1'b0;

  always #5 clk = ~clk;

  leb128_imm_decoder_if bus ();

  leb128_imm_decoder #(.USE_64B(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    if (bus.out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = bus.out_valid;
    if (bus.out_valid && bus.out_ready && !flush) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got value 0x%0h, expected no output", bus.out_value);
      end else begin
        mon_e = sb.pop_front();
        chk("out_value", bus.out_value, mon_e.value);
        chk("out_len", 64'(bus.out_len), 64'(mon_e.len));
        chk("out_error", 64'(bus.out_error), 64'(mon_e.err));
        if (mon_e.lat >= 0) chk("latency", 64'(rise_cyc - cmd_cyc), 64'(mon_e.lat));
      end
    end
  end

  task automatic send_cmd(input logic s, input logic w);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_signed = s;
    bus.cmd_is64   = w;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmd_cyc = cyc;
    if (!bus.cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL cmd_timeout: got cmd_ready 0 expected 1");
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Issue one command with the bytes in bq and queue the expected result.
  task automatic run_seq(input logic s, input logic w, input int gap,
                         input logic [63:0] v, input logic [3:0] l,
                         input logic e, input int lat);
    exp_t x;
    x.value = v; x.len = l; x.err = e; x.lat = lat;
    sb.push_back(x);
    send_cmd(s, w);
    foreach (bq[i]) send_byte(bq[i], (i == 0) ? 0 : gap);
    chk("in_ready_after_last", 64'(bus.in_ready), 64'd0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_signed = 1'b0;
    bus.cmd_is64   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_byte    = 8'h00;
    bus.out_ready  = 1'b1;

    // Outputs during reset
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_value", bus.out_value, 64'd0);
    chk("rst_out_len", 64'(bus.out_len), 64'd0);
    chk("rst_out_error", 64'(bus.out_error), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    bq = '{8'h2A};
    run_seq(1'b0, 1'b0, 0, 64'd42, 4'd1, 1'b0, 2);
    bq = '{8'hE5, 8'h8E, 8'h26};
    run_seq(1'b0, 1'b0, 0, 64'h98765, 4'd3, 1'b0, 4);
    run_seq(1'b0, 1'b0, 2, 64'h98765, 4'd3, 1'b0, 8);
    bq = '{8'h7F};
    run_seq(1'b1, 1'b0, 0, 64'h0000_0000_FFFF_FFFF, 4'd1, 1'b0, 2);
    run_seq(1'b1, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0, 2);
    bq = '{8'hC0, 8'hBB, 8'h78};
    run_seq(1'b1, 1'b1, 0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0, -1);
    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_seq(1'b0, 1'b0, 0, 64'd0, 4'd5, 1'b1, -1);
    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_seq(1'b0, 1'b1, 0, 64'd0, 4'd10, 1'b1, -1);
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
`ifdef LEB128_STRICT_EN
    run_seq(1'b0, 1'b0, 0, 64'd0, 4'd5, 1'b1, -1);
`else
    run_seq(1'b0, 1'b0, 0, 64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0, -1);
`endif
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run_seq(1'b0, 1'b0, 0, 64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0, -1);
    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78};
    run_seq(1'b1, 1'b0, 0, 64'h0000_0000_8000_0000, 4'd5, 1'b0, -1);
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run_seq(1'b0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0, -1);

    // Back-pressure: result held stable while out_ready is low
    begin
      exp_t x;
      x.value = 64'd5; x.len = 4'd1; x.err = 1'b0; x.lat = 2;
      bus.out_ready = 1'b0;
      sb.push_back(x);
      send_cmd(1'b0, 1'b0);
      send_byte(8'h05, 0);
      repeat (3) begin
        @(negedge clk);
        chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_out_value", bus.out_value, 64'd5);
        chk("hold_out_len", 64'(bus.out_len), 64'd1);
        chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      wait_drain();
    end

    // Flush mid-decode: byte in flush cycle not taken, no result emitted
    send_cmd(1'b0, 1'b0);
    send_byte(8'h80, 0);
    @(negedge clk);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h01;
    #1 chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("flush_quiet", 64'(bus.out_valid), 64'd0);
    end
    bq = '{8'h2A};
    run_seq(1'b0, 1'b0, 0, 64'd42, 4'd1, 1'b0, 2);

    // Asynchronous reset mid-decode
    send_cmd(1'b1, 1'b1);
    send_byte(8'hC0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_value", bus.out_value, 64'd0);
    chk("mid_rst_out_len", 64'(bus.out_len), 64'd0);
    chk("mid_rst_out_error", 64'(bus.out_error), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bq = '{8'hE5, 8'h8E, 8'h26};
    run_seq(1'b0, 1'b1, 0, 64'h98765, 4'd3, 1'b0, 4);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/leb128_imm_decoder.md
Name: leb128_imm_decoder

Overview:
- Decodes one LEB128 immediate (wasm `varuint`/`varint`, 32/64-bit) from the code byte stream between the ROM fetch buffer and the CPU decode/execute stage.
- Consumes one byte per cycle from the fetch buffer; returns value, byte length and an error flag.
- The CPU maps the error flag to an `INVALID` trap and advances the PC by the returned length.

Parameters:
- USE_64B, 1: when 1, 64-bit immediates are supported; when 0, cmd_is64 is ignored and all decodes are 32-bit.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; returns to IDLE and drops any in-flight decode.
- cmd_valid  input  1  decode request.
- cmd_ready  output  1  high only in IDLE.
- cmd_signed  input  1  1 = signed (varint), 0 = unsigned.
- cmd_is64  input  1  1 = 64-bit target width.
- in_valid  input  1  code byte available.
- in_ready  output  1  high only in DECODE.
- in_byte  input  8  code byte.
- out_valid  output  1  result held until accepted.
- out_ready  input  1  consumer accepts result.
- out_value  output  64  decoded value.
- out_len  output  4  bytes consumed, 1..10.
- out_error  output  1  malformed encoding.

Behaviour:
- Reset values: cmd_ready=0 during reset then 1 (IDLE); in_ready=0, out_valid=0, out_value=0, out_len=0, out_error=0. Accumulator, count and mode registers are cleared.
- Reset asserted mid-operation clears everything immediately. A partially decoded value is never emitted.
- States: IDLE -> DECODE -> DONE -> IDLE.
- IDLE: on cmd_valid&cmd_ready, latch signed/is64 (is64 forced to 0 if USE_64B=0), clear accumulator and count, go to DECODE.
- DECODE: on each in_valid&in_ready, byte k (k from 0) ORs in_byte[6:0] into accumulator bits [7k+6:7k], clipped at bit 63, and count increments.
  - in_byte[7]=0 (final byte): go to DONE.
  - in_byte[7]=1 and count reaches the maximum (5 for 32-bit, 10 for 64-bit): go to DONE with error.
  - in_valid gaps stall with no state change.
- Finalisation is registered; out_valid rises the cycle after the final byte handshake. Minimum latency is 2 cycles from cmd accept to out_valid for a 1-byte immediate.
- Signed mode: if bit 6 of the final byte is 1 and 7*len < width, bits [width-1:7*len] are set to 1.
- 32-bit mode: out_value[63:32] = 0 always, signed or not. out_value[31:0] holds the truncated result.
- 64-bit mode: the full 64 bits are used.
- On error: out_value=0; out_len = bytes consumed; out_error=1.
- DONE: outputs stable while out_valid&!out_ready. On handshake go to IDLE. A new cmd can be accepted the next cycle; there is no same-cycle turnaround.
- flush: takes priority over every handshake that cycle. Next state IDLE, out_valid=0, and the byte presented that cycle is not consumed (in_ready is deasserted combinationally while flush=1).
- cmd_valid in any state other than IDLE is ignored because cmd_ready=0.

Optional Feature:
- LEB128_STRICT_EN defined: the final byte at maximum length must carry no bits beyond the target width; violating encodings give out_error=1.
  - Unsigned 32: byte5[6:4]==0.
  - Signed 32: byte5[6:3] all equal.
  - Unsigned 64: byte10[6:1]==0.
  - Signed 64: byte10[6:0] equal to 0x00 or 0x7F.
- LEB128_STRICT_EN undefined: surplus bits are silently discarded; only the over-length continuation bit errors.

Decomposition:
- Shared package/header (leb128.vh):
  - LEB_MAX_BYTES_32=5, LEB_MAX_BYTES_64=10.
  - State encodings S_IDLE/S_DECODE/S_DONE.
  - Width selector constants.
- One sub-module, leb128_final_check: purely combinational.
  - Inputs: final byte, count, signed, is64.
  - Outputs: strict-violation flag (tied 0 without LEB128_STRICT_EN) and the sign-extension mask.

Test Plan:
- Unsigned 32, bytes 0x2A -> out_value=42, out_len=1, out_error=0, out_valid 2 cycles after cmd accept.
- Unsigned 32, bytes E5 8E 26 -> 624485 (0x98765), len=3. Repeat with in_valid low 2 cycles between bytes -> same result, delayed 4 cycles.
- Signed 32, 0x7F -> 0x00000000FFFFFFFF, len=1. Signed 64, 0x7F -> 0xFFFFFFFFFFFFFFFF. Signed 64, C0 BB 78 -> -123456 sign-extended, len=3.
- Unsigned 32, 80 80 80 80 80 -> out_error=1, out_len=5, out_value=0, in_ready low after 5th byte. Unsigned 64 with ten 0x80 -> error, len=10.
- Unsigned 32, FF FF FF FF 1F:
  - LEB128_STRICT_EN defined -> error, len=5.
  - LEB128_STRICT_EN undefined -> 0xFFFFFFFF, no error.
  - Variant FF FF FF FF 0F -> 0xFFFFFFFF, no error in both builds.
- Hold out_ready=0 for 3 cycles -> outputs stable and cmd_ready=0. Assert flush mid-decode -> IDLE next cycle, no out_valid. Pulse reset low mid-decode -> all outputs at reset values immediately.
